// File: rtl/axis_tx_arbiter.sv
// Two-port AXI4-Stream packet arbiter: round-robin on packet boundaries,
// one registered output stage, per-port forwarded-packet counters.
module axis_tx_arbiter #(
  parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 128
) (
  input  logic                              axis_aclk,
  input  logic                              axis_resetn,

  input  logic [C_AXIS_DATA_WIDTH-1:0]      s0_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s0_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]     s0_axis_tuser,
  input  logic                              s0_axis_tvalid,
  input  logic                              s0_axis_tlast,
  output logic                              s0_axis_tready,

  input  logic [C_AXIS_DATA_WIDTH-1:0]      s1_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s1_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]     s1_axis_tuser,
  input  logic                              s1_axis_tvalid,
  input  logic                              s1_axis_tlast,
  output logic                              s1_axis_tready,

  output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,

  output logic [31:0]                       pkt_cnt0,
  output logic [31:0]                       pkt_cnt1
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t            state_q;
  logic              last_grant_q;
  logic              armed_q;
  logic [CNT_W-1:0]  cnt0_q;
  logic [CNT_W-1:0]  cnt1_q;
  logic              acc0;
  logic              acc1;
  logic              done0;
  logic              done1;

  // Granted port may push whenever the output stage is empty or draining.
  always_comb begin
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    if (state_q == GRANT0) s0_axis_tready = ~m_axis_tvalid | m_axis_tready;
    if (state_q == GRANT1) s1_axis_tready = ~m_axis_tvalid | m_axis_tready;
  end

  assign acc0  = s0_axis_tvalid & s0_axis_tready;
  assign acc1  = s1_axis_tvalid & s1_axis_tready;
  assign done0 = acc0 & s0_axis_tlast;
  assign done1 = acc1 & s1_axis_tlast;

  // armed_q holds off the first grant until one full cycle out of reset.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      armed_q      <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (armed_q) begin
            if (s0_axis_tvalid && s1_axis_tvalid)
              state_q <= last_grant_q ? GRANT0 : GRANT1;
            else if (s0_axis_tvalid)
              state_q <= GRANT0;
            else if (s1_axis_tvalid)
              state_q <= GRANT1;
          end
        end
        GRANT0: begin
          if (done0) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
          end
        end
        GRANT1: begin
          if (done1) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Counters are rewritten every cycle and wrap naturally.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_q + CNT_W'(done0);
      cnt1_q <= cnt1_q + CNT_W'(done1);
    end
  end

  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;

  // Single output stage; payload is held untouched while stalled.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
    end else if (acc0) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= s0_axis_tlast;
      m_axis_tdata  <= s0_axis_tdata;
      m_axis_tkeep  <= s0_axis_tkeep;
      m_axis_tuser  <= s0_axis_tuser;
    end else if (acc1) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= s1_axis_tlast;
      m_axis_tdata  <= s1_axis_tdata;
      m_axis_tkeep  <= s1_axis_tkeep;
      m_axis_tuser  <= s1_axis_tuser;
    end else if (m_axis_tvalid && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule
